// File: rtl/xgen_link_sched.sv
// Sweeps links 1..NUM_LINKS: accepts a saturated sin/cos pair per link, lets the
// shared xform path settle, strobes capture, then presents the result downstream.
module xgen_link_sched #(
   parameter int WIDTH         = 32,
   parameter int DECIMAL_BITS  = 16,
   parameter int NUM_LINKS     = 7,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_in,
   input  logic                    sincos_valid_in,
   output logic                    sincos_ready_out,
   input  logic signed [WIDTH-1:0] sinq_in,
   input  logic signed [WIDTH-1:0] cosq_in,
   output logic signed [WIDTH-1:0] xgen_sinq_out,
   output logic signed [WIDTH-1:0] xgen_cosq_out,
   output logic [2:0]              link_sel_out,
   output logic                    xform_capture_out,
   output logic                    link_valid_out,
   input  logic                    link_ready_in,
   output logic                    busy_out,
   output logic                    done_out,
   output logic                    sat_flag_out
);

   generate
      if (NUM_LINKS < 1 || NUM_LINKS > 7) begin : g_bad_links
         $error("xgen_link_sched: NUM_LINKS must be in 1..7");
      end
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("xgen_link_sched: SETTLE_CYCLES must be in 1..15");
      end
      if (DECIMAL_BITS < 0 || DECIMAL_BITS > WIDTH - 2) begin : g_bad_frac
         $error("xgen_link_sched: DECIMAL_BITS must leave room for +1.0 and sign");
      end
   endgenerate

   localparam logic signed [WIDTH-1:0] POS_ONE     = WIDTH'(1) << DECIMAL_BITS;
   localparam logic signed [WIDTH-1:0] NEG_ONE     = -POS_ONE;
   localparam logic [2:0]              LAST_LINK   = 3'(NUM_LINKS);
   localparam logic [3:0]              SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_CAPTURE,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [2:0]              link_q, link_d;
   logic signed [WIDTH-1:0] sin_q, sin_d;
   logic signed [WIDTH-1:0] cos_q, cos_d;
   logic                    sat_q, sat_d;

   // Index 0 carries sin, index 1 carries cos; both clamp to [-1.0, +1.0].
   logic signed [WIDTH-1:0] op_raw [2];
   logic signed [WIDTH-1:0] op_sat [2];
   logic [1:0]              op_clamp;

   assign op_raw[0] = sinq_in;
   assign op_raw[1] = cosq_in;

   for (genvar gi = 0; gi < 2; gi++) begin : g_sat
      assign op_clamp[gi] = (op_raw[gi] > POS_ONE) || (op_raw[gi] < NEG_ONE);
      assign op_sat[gi]   = (op_raw[gi] > POS_ONE) ? POS_ONE :
                            (op_raw[gi] < NEG_ONE) ? NEG_ONE : op_raw[gi];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         link_q  <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         link_q  <= link_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      link_d  = link_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      sat_d   = sat_q;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_LOAD;
               link_d  = 3'd1;
               sat_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (sincos_valid_in) begin
               sin_d   = op_sat[0];
               cos_d   = op_sat[1];
               sat_d   = sat_q | (|op_clamp);
               cnt_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // The counter holds SETTLE_CYCLES-1 on entry, so this state lasts SETTLE_CYCLES cycles.
            if (cnt_q == 4'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_CAPTURE: begin
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (link_ready_in) begin
               if (link_q == LAST_LINK) begin
                  state_d = S_DONE;
                  link_d  = 3'd0;
               end else begin
                  state_d = S_LOAD;
                  link_d  = link_q + 3'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            link_d  = 3'd0;
         end
         default: begin
            state_d = S_IDLE;
            link_d  = 3'd0;
         end
      endcase
   end

   assign sincos_ready_out  = (state_q == S_LOAD);
   assign xform_capture_out = (state_q == S_CAPTURE);
   assign link_valid_out    = (state_q == S_PRESENT);
   assign done_out          = (state_q == S_DONE);
   assign busy_out          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign link_sel_out      = link_q;
   assign xgen_sinq_out     = sin_q;
   assign xgen_cosq_out     = cos_q;
   assign sat_flag_out      = sat_q;

endmodule

// File: doc/xgen_link_sched.md
Name: xgen_link_sched

Overview:
- Sequences one joint's sin/cos pair per link into the bank of per-link transformation-matrix generators (links 1..NUM_LINKS).
- Steers the operands through a shared link-select bus and waits for the combinational xform path to settle.
- Emits one capture strobe per link, then presents each link's xform to the downstream RNEA stage under a valid/ready handshake.
- Sits between the sin/cos front end and the forward-pass datapath; one sweep covers all links in order.

Parameters:
WIDTH, 32, fixed-point word width of sinq/cosq
DECIMAL_BITS, 16, fractional bits; 1.0 = 2^DECIMAL_BITS
NUM_LINKS, 7, links per sweep (indices 1..NUM_LINKS)
SETTLE_CYCLES, 2, cycles between operand register update and capture strobe (1..15)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start_in  input  1  begin a sweep; sampled only in IDLE
sincos_valid_in  input  1  sinq_in/cosq_in valid for current link
sincos_ready_out  output  1  scheduler accepts a sin/cos pair this cycle
sinq_in  input  WIDTH  signed sin(q), Q(WIDTH-DECIMAL_BITS).DECIMAL_BITS
cosq_in  input  WIDTH  signed cos(q)
xgen_sinq_out  output  WIDTH  registered, saturated sin operand to xgen bank
xgen_cosq_out  output  WIDTH  registered, saturated cos operand to xgen bank
link_sel_out  output  3  link index 1..NUM_LINKS driving the xgen output mux; 0 when idle
xform_capture_out  output  1  one-cycle strobe: latch selected xgen outputs
link_valid_out  output  1  captured xform for link_sel_out available downstream
link_ready_in  input  1  downstream consumes the captured xform
busy_out  output  1  sweep in progress
done_out  output  1  one-cycle pulse after the last link handshakes
sat_flag_out  output  1  sticky per sweep: an input magnitude exceeded 1.0

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; link_sel_out=0; settle counter=0; sat_flag_out=0.
- States: IDLE, LOAD, SETTLE, CAPTURE, PRESENT, DONE.
- IDLE: start_in=1 -> LOAD, link_sel_out=1, busy_out=1, sat_flag_out cleared. start_in is ignored outside IDLE.
- LOAD: sincos_ready_out=1 (combinational from state).
  - On sincos_valid_in & ready: register saturated operands, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- Saturation: operand > +2^DECIMAL_BITS -> +2^DECIMAL_BITS; operand < -2^DECIMAL_BITS -> -2^DECIMAL_BITS; otherwise passed unchanged. Any clamp sets sat_flag_out, which holds until the next start.
- SETTLE: counter decrements each cycle; at 0 -> CAPTURE. Operands and link_sel_out stay stable.
- CAPTURE: xform_capture_out=1 for exactly one cycle -> PRESENT. Capture occurs exactly SETTLE_CYCLES+1 cycles after the accepting edge.
- PRESENT: link_valid_out=1, held until link_ready_in=1.
  - link_valid_out never drops without a handshake; link_sel_out and operands are held.
  - On handshake with link_sel_out < NUM_LINKS: link_sel_out++ and go to LOAD. The next pair is accepted no earlier than the following cycle.
  - On handshake with link_sel_out == NUM_LINKS: go to DONE.
- DONE: done_out=1 for one cycle; busy_out=0, link_sel_out=0; return to IDLE. start_in in DONE is ignored.
- Minimum per-link latency, accept to valid: SETTLE_CYCLES+2 cycles.
- Minimum sweep length: NUM_LINKS*(SETTLE_CYCLES+3)+2 cycles.
- sincos_valid_in outside LOAD is ignored; no data is stored.
- Reset asserted mid-sweep aborts immediately: no done_out, the captured link is not presented, and no partial state survives.
- link_sel_out is 3 bits; NUM_LINKS>7 is illegal (elaboration check).

Test Plan:
- Nominal sweep, SETTLE_CYCLES=2, valid and ready always high:
  - link_sel_out steps 1..7.
  - xform_capture_out fires 3 cycles after each accept.
  - done_out pulses once at cycle 7*5+2=37 after start.
  - sat_flag_out=0.
- Saturation on link 3, sinq_in=32'sd70000 and cosq_in=-32'sd90000:
  - xgen_sinq_out=65536, xgen_cosq_out=-65536.
  - sat_flag_out rises and stays 1 through done.
  - Next start clears it.
- Backpressure: hold link_ready_in=0 for 10 cycles on link 5.
  - link_valid_out stays 1; link_sel_out=5 and operands stay constant.
  - sincos_ready_out stays 0; no extra capture strobe.
- Input starvation: drop sincos_valid_in for 6 cycles in LOAD of link 2.
  - Scheduler idles in LOAD with sincos_ready_out=1 and no capture.
  - Resumes normally when valid returns.
- Reset mid-SETTLE of link 4:
  - All outputs 0 asynchronously.
  - No done_out; a new start restarts at link_sel_out=1.
- start_in held high for the whole sweep: exactly one sweep and one done_out, then a second sweep begins from IDLE the cycle after DONE.
